// File: rtl/open_nic_calc_shell.sv
// open_nic_calc_shell
//   Single-clock NIC shell with an in-line UDP calculator between the QDMA H2C
//   stream and the CMAC TX stream, plus an AXI4-Lite control register block.
//
// Ports:
//   axis_aclk / powerup_rstn       clock, asynchronous active-low reset
//   axil_aclk                      axis_aclk forwarded
//   shell_rst_done/user_rst_done   all ones once the reset counter expires
//   s_axis_qdma_h2c_sim_*          input AXI4-Stream (tuser_mty = empty bytes on tlast)
//   m_axis_cmac_tx_sim_*           output AXI4-Stream with tkeep
//   s_axil_sim_*                   AXI4-Lite slave: CTRL 0x1000, ADD_OP 0x1004,
//                                  SUB_OP 0x1008, UDP_PORT 0x100C
module open_nic_calc_shell #(
  parameter int DATA_WIDTH      = 512,
  parameter int RST_DONE_CYCLES = 16
) (
  input  logic                        axis_aclk,
  input  logic                        powerup_rstn,
  output logic                        axil_aclk,
  output logic [31:0]                 shell_rst_done,
  output logic [31:0]                 user_rst_done,

  input  logic [DATA_WIDTH-1:0]       s_axis_qdma_h2c_sim_tdata,
  input  logic                        s_axis_qdma_h2c_sim_tvalid,
  output logic                        s_axis_qdma_h2c_sim_tready,
  input  logic                        s_axis_qdma_h2c_sim_tlast,
  input  logic                        s_axis_qdma_h2c_sim_tuser_err,
  input  logic                        s_axis_qdma_h2c_sim_tuser_zero_byte,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] s_axis_qdma_h2c_sim_tuser_mty,
  input  logic [31:0]                 s_axis_qdma_h2c_sim_tuser_mdata,
  input  logic [10:0]                 s_axis_qdma_h2c_sim_tuser_qid,
  input  logic [2:0]                  s_axis_qdma_h2c_sim_tuser_port_id,
  input  logic [31:0]                 s_axis_qdma_h2c_sim_tcrc,

  output logic [DATA_WIDTH-1:0]       m_axis_cmac_tx_sim_tdata,
  output logic [DATA_WIDTH/8-1:0]     m_axis_cmac_tx_sim_tkeep,
  output logic                        m_axis_cmac_tx_sim_tvalid,
  output logic                        m_axis_cmac_tx_sim_tlast,
  output logic                        m_axis_cmac_tx_sim_tuser_err,
  input  logic                        m_axis_cmac_tx_sim_tready,

  input  logic                        s_axil_sim_awvalid,
  input  logic [31:0]                 s_axil_sim_awaddr,
  output logic                        s_axil_sim_awready,
  input  logic                        s_axil_sim_wvalid,
  input  logic [31:0]                 s_axil_sim_wdata,
  output logic                        s_axil_sim_wready,
  output logic                        s_axil_sim_bvalid,
  output logic [1:0]                  s_axil_sim_bresp,
  input  logic                        s_axil_sim_bready,
  input  logic                        s_axil_sim_arvalid,
  input  logic [31:0]                 s_axil_sim_araddr,
  output logic                        s_axil_sim_arready,
  output logic                        s_axil_sim_rvalid,
  output logic [31:0]                 s_axil_sim_rdata,
  output logic [1:0]                  s_axil_sim_rresp,
  input  logic                        s_axil_sim_rready
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int MW = $clog2(KW);
  localparam logic [15:0] DONE_AT = 16'(RST_DONE_CYCLES - 1);

  logic        rst_done;
  logic [15:0] rst_cnt;

  logic        ctrl_en;
  logic [15:0] add_op, sub_op, udp_port;

  logic                  first;
  logic                  s1_valid, s1_last, s1_err;
  logic [MW-1:0]         s1_mty;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s2_ready, accept;

  logic [DATA_WIDTH-1:0] proc_data;
  logic [KW-1:0]         keep_all;
  logic                  hit;
  logic [31:0]           op_a, op_b, result;
  logic [15:0]           opcode;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_qdma_h2c_sim_tuser_zero_byte, s_axis_qdma_h2c_sim_tuser_mdata,
                           s_axis_qdma_h2c_sim_tuser_qid, s_axis_qdma_h2c_sim_tuser_port_id,
                           s_axis_qdma_h2c_sim_tcrc, s_axil_sim_wdata[31:16]};

  assign axil_aclk        = axis_aclk;
  assign shell_rst_done   = {32{rst_done}};
  assign user_rst_done    = {32{rst_done}};
  assign s_axil_sim_bresp = 2'b00;
  assign s_axil_sim_rresp = 2'b00;
  assign keep_all         = '1;

  always_ff @(posedge axis_aclk or negedge powerup_rstn) begin
    if (!powerup_rstn) begin
      rst_cnt  <= '0;
      rst_done <= 1'b0;
    end else if (!rst_done) begin
      rst_cnt  <= rst_cnt + 16'd1;
      rst_done <= (rst_cnt == DONE_AT);
    end
  end

  // ---------------- stream path ----------------
  assign s2_ready = !m_axis_cmac_tx_sim_tvalid || m_axis_cmac_tx_sim_tready;
  assign s_axis_qdma_h2c_sim_tready = rst_done && (!s1_valid || s2_ready);
  assign accept = s_axis_qdma_h2c_sim_tvalid && s_axis_qdma_h2c_sim_tready;

  assign opcode = {s_axis_qdma_h2c_sim_tdata[8*46 +: 8], s_axis_qdma_h2c_sim_tdata[8*47 +: 8]};
  assign op_a   = {s_axis_qdma_h2c_sim_tdata[8*48 +: 8], s_axis_qdma_h2c_sim_tdata[8*49 +: 8],
                   s_axis_qdma_h2c_sim_tdata[8*50 +: 8], s_axis_qdma_h2c_sim_tdata[8*51 +: 8]};
  assign op_b   = {s_axis_qdma_h2c_sim_tdata[8*52 +: 8], s_axis_qdma_h2c_sim_tdata[8*53 +: 8],
                   s_axis_qdma_h2c_sim_tdata[8*54 +: 8], s_axis_qdma_h2c_sim_tdata[8*55 +: 8]};

  assign hit = first && ctrl_en
    && ({s_axis_qdma_h2c_sim_tdata[8*12 +: 8], s_axis_qdma_h2c_sim_tdata[8*13 +: 8]} == 16'h8100)
    && ({s_axis_qdma_h2c_sim_tdata[8*16 +: 8], s_axis_qdma_h2c_sim_tdata[8*17 +: 8]} == 16'h0800)
    && (s_axis_qdma_h2c_sim_tdata[8*18 +: 8] == 8'h45)
    && (s_axis_qdma_h2c_sim_tdata[8*27 +: 8] == 8'h11)
    && ({s_axis_qdma_h2c_sim_tdata[8*40 +: 8], s_axis_qdma_h2c_sim_tdata[8*41 +: 8]} == udp_port);

  always_comb begin
    proc_data = s_axis_qdma_h2c_sim_tdata;
    result    = '0;
    if (hit && (opcode == add_op || opcode == sub_op)) begin
      // ADD is tested first so it wins when both opcodes are programmed equal
      result = (opcode == add_op) ? op_a + op_b : op_a - op_b;
      proc_data[8*56 +: 8] = result[31:24];
      proc_data[8*57 +: 8] = result[23:16];
      proc_data[8*58 +: 8] = result[15:8];
      proc_data[8*59 +: 8] = result[7:0];
    end
  end

  always_ff @(posedge axis_aclk or negedge powerup_rstn) begin
    if (!powerup_rstn) begin
      first    <= 1'b1;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_err   <= 1'b0;
      s1_mty   <= '0;
      s1_data  <= '0;
      m_axis_cmac_tx_sim_tvalid    <= 1'b0;
      m_axis_cmac_tx_sim_tdata     <= '0;
      m_axis_cmac_tx_sim_tkeep     <= '0;
      m_axis_cmac_tx_sim_tlast     <= 1'b0;
      m_axis_cmac_tx_sim_tuser_err <= 1'b0;
    end else begin
      if (accept) begin
        first    <= s_axis_qdma_h2c_sim_tlast;
        s1_valid <= 1'b1;
        s1_data  <= proc_data;
        s1_last  <= s_axis_qdma_h2c_sim_tlast;
        s1_err   <= s_axis_qdma_h2c_sim_tuser_err;
        s1_mty   <= s_axis_qdma_h2c_sim_tuser_mty;
      end else if (s2_ready) begin
        s1_valid <= 1'b0;
      end
      if (s2_ready) begin
        m_axis_cmac_tx_sim_tvalid <= s1_valid;
        if (s1_valid) begin
          m_axis_cmac_tx_sim_tdata     <= s1_data;
          m_axis_cmac_tx_sim_tlast     <= s1_last;
          m_axis_cmac_tx_sim_tuser_err <= s1_err;
          m_axis_cmac_tx_sim_tkeep     <= s1_last ? (keep_all >> s1_mty) : keep_all;
        end
      end
    end
  end

  // ---------------- AXI4-Lite registers ----------------
  always_ff @(posedge axis_aclk or negedge powerup_rstn) begin
    if (!powerup_rstn) begin
      s_axil_sim_awready <= 1'b0;
      s_axil_sim_wready  <= 1'b0;
      s_axil_sim_bvalid  <= 1'b0;
      s_axil_sim_arready <= 1'b0;
      s_axil_sim_rvalid  <= 1'b0;
      s_axil_sim_rdata   <= '0;
      ctrl_en  <= 1'b0;
      add_op   <= 16'h000D;
      sub_op   <= 16'h001A;
      udp_port <= 16'h10E1;
    end else begin
      s_axil_sim_awready <= 1'b0;
      s_axil_sim_wready  <= 1'b0;
      s_axil_sim_arready <= 1'b0;

      if (s_axil_sim_awvalid && s_axil_sim_wvalid && !s_axil_sim_bvalid && !s_axil_sim_awready) begin
        s_axil_sim_awready <= 1'b1;
        s_axil_sim_wready  <= 1'b1;
      end
      if (s_axil_sim_awready && s_axil_sim_awvalid && s_axil_sim_wvalid) begin
        s_axil_sim_bvalid <= 1'b1;
        case (s_axil_sim_awaddr)
          32'h0000_1000: ctrl_en  <= s_axil_sim_wdata[0];
          32'h0000_1004: add_op   <= s_axil_sim_wdata[15:0];
          32'h0000_1008: sub_op   <= s_axil_sim_wdata[15:0];
          32'h0000_100C: udp_port <= s_axil_sim_wdata[15:0];
          default: ;
        endcase
      end
      if (s_axil_sim_bvalid && s_axil_sim_bready) s_axil_sim_bvalid <= 1'b0;

      if (s_axil_sim_arvalid && !s_axil_sim_rvalid && !s_axil_sim_arready) s_axil_sim_arready <= 1'b1;
      if (s_axil_sim_arready && s_axil_sim_arvalid) begin
        s_axil_sim_rvalid <= 1'b1;
        case (s_axil_sim_araddr)
          32'h0000_1000: s_axil_sim_rdata <= {31'd0, ctrl_en};
          32'h0000_1004: s_axil_sim_rdata <= {16'd0, add_op};
          32'h0000_1008: s_axil_sim_rdata <= {16'd0, sub_op};
          32'h0000_100C: s_axil_sim_rdata <= {16'd0, udp_port};
          default:       s_axil_sim_rdata <= '0;
        endcase
      end
      if (s_axil_sim_rvalid && s_axil_sim_rready) s_axil_sim_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_open_nic_calc_shell.sv
// Directed self-checking bench for open_nic_calc_shell.
module tb_open_nic_calc_shell;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aclk_fwd;
  logic [31:0]  shell_done, user_done;
  logic [511:0] s_tdata = '0;
  logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_err = 1'b0;
  logic [5:0]   s_mty = '0;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid, m_tlast, m_err, m_tready = 1'b1;
  logic         awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [31:0]  awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [1:0]   bresp, rresp;
  logic         arvalid = 1'b0, arready, rvalid, rready = 1'b0;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  open_nic_calc_shell #(.DATA_WIDTH(512), .RST_DONE_CYCLES(16)) dut (
    .axis_aclk(clk), .powerup_rstn(rst_n), .axil_aclk(aclk_fwd),
    .shell_rst_done(shell_done), .user_rst_done(user_done),
    .s_axis_qdma_h2c_sim_tdata(s_tdata), .s_axis_qdma_h2c_sim_tvalid(s_tvalid),
    .s_axis_qdma_h2c_sim_tready(s_tready), .s_axis_qdma_h2c_sim_tlast(s_tlast),
    .s_axis_qdma_h2c_sim_tuser_err(s_err), .s_axis_qdma_h2c_sim_tuser_zero_byte(1'b0),
    .s_axis_qdma_h2c_sim_tuser_mty(s_mty), .s_axis_qdma_h2c_sim_tuser_mdata(32'h0),
    .s_axis_qdma_h2c_sim_tuser_qid(11'h0), .s_axis_qdma_h2c_sim_tuser_port_id(3'h0),
    .s_axis_qdma_h2c_sim_tcrc(32'h0),
    .m_axis_cmac_tx_sim_tdata(m_tdata), .m_axis_cmac_tx_sim_tkeep(m_tkeep),
    .m_axis_cmac_tx_sim_tvalid(m_tvalid), .m_axis_cmac_tx_sim_tlast(m_tlast),
    .m_axis_cmac_tx_sim_tuser_err(m_err), .m_axis_cmac_tx_sim_tready(m_tready),
    .s_axil_sim_awvalid(awvalid), .s_axil_sim_awaddr(awaddr), .s_axil_sim_awready(awready),
    .s_axil_sim_wvalid(wvalid), .s_axil_sim_wdata(wdata), .s_axil_sim_wready(wready),
    .s_axil_sim_bvalid(bvalid), .s_axil_sim_bresp(bresp), .s_axil_sim_bready(bready),
    .s_axil_sim_arvalid(arvalid), .s_axil_sim_araddr(araddr), .s_axil_sim_arready(arready),
    .s_axil_sim_rvalid(rvalid), .s_axil_sim_rdata(rdata), .s_axil_sim_rresp(rresp),
    .s_axil_sim_rready(rready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // VLAN/IPv4/UDP frame, filler bytes are a non-trivial pattern
  function automatic logic [511:0] mkframe(input logic [15:0] port, input logic [15:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [15:0] csum);
    logic [511:0] f;
    for (int i = 0; i < 64; i++) f[8*i +: 8] = 8'(i * 7 + 3);
    f[8*12 +: 8] = 8'h81; f[8*13 +: 8] = 8'h00; f[8*14 +: 8] = 8'h00; f[8*15 +: 8] = 8'h05;
    f[8*16 +: 8] = 8'h08; f[8*17 +: 8] = 8'h00; f[8*18 +: 8] = 8'h45; f[8*27 +: 8] = 8'h11;
    f[8*40 +: 8] = port[15:8]; f[8*41 +: 8] = port[7:0];
    f[8*44 +: 8] = csum[15:8]; f[8*45 +: 8] = csum[7:0];
    f[8*46 +: 8] = op[15:8];   f[8*47 +: 8] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      f[8*(48+i) +: 8] = a[8*(3-i) +: 8];
      f[8*(52+i) +: 8] = b[8*(3-i) +: 8];
      f[8*(56+i) +: 8] = 8'h00;
    end
    return f;
  endfunction

  function automatic logic [511:0] with_result(input logic [511:0] f, input logic [31:0] r);
    logic [511:0] g = f;
    for (int i = 0; i < 4; i++) g[8*(56+i) +: 8] = r[8*(3-i) +: 8];
    return g;
  endfunction

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data);
    logic seen = 1'b0;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = awready;
    end
    chk("wr_awready_seen", seen, 1'b1);
    chk("wr_wready_with_aw", wready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_awready_pulse", awready, 1'b0);
    chk("wr_bvalid", bvalid, 1'b1);
    @(negedge clk);
    chk("wr_bvalid_hold", bvalid, 1'b1);
    chk("wr_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wr_bvalid_clear", bvalid, 1'b0);
  endtask

  task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic seen = 1'b0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = arready;
    end
    chk({tag, "_arready_seen"}, seen, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rdata"}, rdata, exp);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, "_rvalid_clear"}, rvalid, 1'b0);
  endtask

  // single-beat frame with no backpressure: checks exact 2-cycle latency
  task automatic send_single(input logic [511:0] frame, input logic [511:0] exp,
                             input logic err, input string tag);
    @(negedge clk);
    s_tdata = frame; s_tvalid = 1'b1; s_tlast = 1'b1; s_mty = 6'd0; s_err = err;
    #1 chk({tag, "_tready"}, s_tready, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0;
    chk({tag, "_lat1_novalid"}, m_tvalid, 1'b0);
    @(negedge clk);
    chk({tag, "_tvalid"}, m_tvalid, 1'b1);
    chk({tag, "_tdata"}, m_tdata, exp);
    chk({tag, "_tkeep"}, m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_tlast"}, m_tlast, 1'b1);
    chk({tag, "_terr"}, m_err, err);
  endtask

  logic [511:0] f, beats [3], expb [3];
  int unsigned  bi, oi;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_shell_done", shell_done, 32'h0);
    chk("rst_axil_outs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("done_early", shell_done, 32'h0);
    chk("tready_early", s_tready, 1'b0);
    @(negedge clk);
    chk("shell_done", shell_done, 32'hFFFF_FFFF);
    chk("user_done", user_done, 32'hFFFF_FFFF);
    chk("tready_after_done", s_tready, 1'b1);

    // register defaults and unmapped read
    axil_read(32'h1000, 32'h0, "rd_ctrl_rst");
    axil_read(32'h1004, 32'h0000_000D, "rd_add_rst");
    axil_read(32'h1008, 32'h0000_001A, "rd_sub_rst");
    axil_read(32'h100C, 32'h0000_10E1, "rd_port_rst");
    axil_read(32'h2000, 32'h0, "rd_unmapped");

    // disabled: frame passes unchanged
    f = mkframe(16'd4321, 16'h001A, 32'd3, 32'd2, 16'h0000);
    send_single(f, f, 1'b0, "disabled");

    axil_write(32'h1000, 32'h1);
    axil_read(32'h1000, 32'h1, "rd_ctrl_en");
    axil_write(32'h3000, 32'hFFFF_FFFF);
    axil_read(32'h3000, 32'h0, "rd_unmapped_wr");

    f = mkframe(16'd4321, 16'h001A, 32'd3, 32'd2, 16'h0000);
    send_single(f, with_result(f, 32'h0000_0001), 1'b0, "sub_3_2");
    f = mkframe(16'd4321, 16'h000D, 32'd3, 32'd2, 16'h4D59);
    send_single(f, with_result(f, 32'h0000_0005), 1'b0, "add_csum");
    f = mkframe(16'd4321, 16'h001A, 32'd2, 32'd3, 16'h0000);
    send_single(f, with_result(f, 32'hFFFF_FFFF), 1'b1, "sub_wrap_err");
    f = mkframe(16'd4322, 16'h000D, 32'd3, 32'd2, 16'h0000);
    send_single(f, f, 1'b0, "wrong_port");
    f = mkframe(16'd4321, 16'h0099, 32'd3, 32'd2, 16'h0000);
    send_single(f, f, 1'b0, "bad_opcode");
    f = mkframe(16'hFFFF, 16'h000D, 32'hFFFF_FFFF, 32'd2, 16'h0000);
    axil_write(32'h100C, 32'h0000_FFFF);
    send_single(f, with_result(f, 32'h0000_0001), 1'b0, "add_wrap_newport");
    axil_write(32'h100C, 32'h0000_10E1);

    // multi-beat with output backpressure; later beats carry a matching header
    beats[0] = mkframe(16'd4321, 16'h000D, 32'd7, 32'd8, 16'h1234);
    beats[1] = mkframe(16'd4321, 16'h000D, 32'd1, 32'd1, 16'h0000);
    beats[2] = mkframe(16'd4321, 16'h001A, 32'd9, 32'd1, 16'h0000);
    expb[0]  = with_result(beats[0], 32'h0000_000F);
    expb[1]  = beats[1];
    expb[2]  = beats[2];
    bi = 0; oi = 0;
    for (int cyc = 0; cyc < 60 && oi < 3; cyc++) begin
      @(negedge clk);
      m_tready = (cyc % 3) != 1;
      if (bi < 3) begin
        s_tvalid = 1'b1; s_tdata = beats[bi]; s_tlast = (bi == 2); s_mty = (bi == 2) ? 6'd6 : 6'd0;
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0; s_mty = 6'd0;
      end
      #1;
      if (m_tvalid && m_tready) begin
        chk("mb_tdata", m_tdata, expb[oi]);
        chk("mb_tlast", m_tlast, oi == 2);
        chk("mb_tkeep", m_tkeep, (oi == 2) ? 64'h03FF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
        oi++;
      end
      if (s_tvalid && s_tready) bi++;
    end
    chk("mb_beats_out", oi, 3);
    chk("mb_beats_in", bi, 3);
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mb_no_dup", m_tvalid, 1'b0);

    // next frame after the multi-beat one is a first beat again
    f = mkframe(16'd4321, 16'h000D, 32'd100, 32'd23, 16'h0000);
    send_single(f, with_result(f, 32'd123), 1'b0, "after_multi");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
